// File: rtl/brent_kung_adder16.sv
// 16-bit Brent-Kung parallel-prefix adder with carry-in, carry-out and one output register stage.
// The carry network is an explicit prefix tree: a 4-level up-sweep builds group generates at
// indices 1, 3, 7 and 15. A 3-level down-sweep then fills in every remaining prefix.
module brent_kung_adder16 #(
   parameter int unsigned WIDTH = 16  // only 16 is supported; the tree below is hard-wired
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);

   // Prefix operator: (G,P)hi o (G,P)lo = (Ghi | Phi&Glo, Phi&Plo), packed as {G, P}.
   function automatic logic [1:0] pfx_op(input logic g_hi, input logic p_hi,
                                         input logic g_lo, input logic p_lo);
      pfx_op = {g_hi | (p_hi & g_lo), p_hi & p_lo};
   endfunction

   // Bit-level generate/propagate; p_bit is kept untouched for the final sum XOR.
   logic [15:0] g_bit, p_bit;

   // Group signals after each tree level. Entry i of stage s holds (G,P) over [i:j]
   // for the widest span resolved so far at index i.
   logic [15:0] g_s0, p_s0;  // pre-processing, cin folded into bit 0
   logic [15:0] g_s1, p_s1;  // up-sweep span 1
   logic [15:0] g_s2, p_s2;  // up-sweep span 2
   logic [15:0] g_s3, p_s3;  // up-sweep span 4
   logic [15:0] g_s4, p_s4;  // up-sweep span 8
   logic [15:0] g_s5, p_s5;  // down-sweep level 3
   logic [15:0] g_s6, p_s6;  // down-sweep level 2
   logic [15:0] g_s7, p_s7;  // down-sweep level 1, every G[i:0] now complete

   logic [15:0] carry;
   logic [15:0] sum_d, sum_q;
   logic        c_out_d, c_out_q;

   // Pre-processing: bitwise generate/propagate, with cin folded into G0 so G[i:0] is the carry.
   always_comb begin
      g_bit   = a & b;
      p_bit   = a ^ b;
      g_s0    = g_bit;
      p_s0    = p_bit;
      g_s0[0] = g_bit[0] | (p_bit[0] & cin);
   end

   // Up-sweep level 1: every odd index absorbs its even neighbour.
   always_comb begin
      g_s1 = g_s0;
      p_s1 = p_s0;
      for (int i = 1; i < 16; i += 2) begin
         {g_s1[i], p_s1[i]} = pfx_op(g_s0[i], p_s0[i], g_s0[i-1], p_s0[i-1]);
      end
   end

   // Up-sweep level 2: indices 3, 7, 11, 15 combine with span 2.
   always_comb begin
      g_s2 = g_s1;
      p_s2 = p_s1;
      for (int i = 3; i < 16; i += 4) begin
         {g_s2[i], p_s2[i]} = pfx_op(g_s1[i], p_s1[i], g_s1[i-2], p_s1[i-2]);
      end
   end

   // Up-sweep level 3: indices 7 and 15 combine with span 4.
   always_comb begin
      g_s3 = g_s2;
      p_s3 = p_s2;
      for (int i = 7; i < 16; i += 8) begin
         {g_s3[i], p_s3[i]} = pfx_op(g_s2[i], p_s2[i], g_s2[i-4], p_s2[i-4]);
      end
   end

   // Up-sweep level 4: index 15 combines with span 8, giving G[15:0].
   always_comb begin
      g_s4 = g_s3;
      p_s4 = p_s3;
      {g_s4[15], p_s4[15]} = pfx_op(g_s3[15], p_s3[15], g_s3[7], p_s3[7]);
   end

   // Down-sweep level 3: [11:8] extended by [7:0] gives G[11:0].
   always_comb begin
      g_s5 = g_s4;
      p_s5 = p_s4;
      {g_s5[11], p_s5[11]} = pfx_op(g_s4[11], p_s4[11], g_s4[7], p_s4[7]);
   end

   // Down-sweep level 2: odd indices 5, 9, 13 extended by the nearest complete prefix below.
   always_comb begin
      g_s6 = g_s5;
      p_s6 = p_s5;
      {g_s6[5],  p_s6[5]}  = pfx_op(g_s5[5],  p_s5[5],  g_s5[3],  p_s5[3]);
      {g_s6[9],  p_s6[9]}  = pfx_op(g_s5[9],  p_s5[9],  g_s5[7],  p_s5[7]);
      {g_s6[13], p_s6[13]} = pfx_op(g_s5[13], p_s5[13], g_s5[11], p_s5[11]);
   end

   // Down-sweep level 1: each even index above 0 combines with the complete odd prefix below it.
   always_comb begin
      g_s7 = g_s6;
      p_s7 = p_s6;
      for (int i = 2; i < 16; i += 2) begin
         {g_s7[i], p_s7[i]} = pfx_op(g_s6[i], p_s6[i], g_s6[i-1], p_s6[i-1]);
      end
   end

   // Carries into each bit, then the sum and carry-out that feed the output register.
   always_comb begin
      carry[0]    = cin;
      carry[15:1] = g_s7[14:0];
      sum_d       = p_bit ^ carry;
      c_out_d     = g_s7[15];
   end

   // Output register with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_q   <= 16'h0000;
         c_out_q <= 1'b0;
      end else begin
         sum_q   <= sum_d;
         c_out_q <= c_out_d;
      end
   end

   assign sum   = sum_q;
   assign c_out = c_out_q;

endmodule

// File: tb/tb_brent_kung_adder16.sv
// Directed bench for brent_kung_adder16: reset, carry boundary cases, a back-to-back stream and
// a reset in the middle of a stream. All expected values are hand-computed constants.
module tb_brent_kung_adder16;

   logic        clk;
   logic        rst_n;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic [15:0] sum;
   logic        c_out;

   int unsigned n_vec;
   int unsigned n_err;

   brent_kung_adder16 #(
      .WIDTH(16)
   ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .sum  (sum),
      .c_out(c_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got {c_out,sum}=%05h, expected %05h", tag, got, exp);
      end
   endtask

   // Drive one vector on the falling edge, then check the registered result just after the
   // next rising edge. Consecutive calls therefore give one new operation per cycle.
   task automatic step(input string tag, input logic rst_v, input logic [15:0] a_v,
                       input logic [15:0] b_v, input logic cin_v, input logic [16:0] exp);
      @(negedge clk);
      rst_n = rst_v;
      a     = a_v;
      b     = b_v;
      cin   = cin_v;
      @(posedge clk);
      #1;
      check(tag, {c_out, sum}, exp);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      a     = 16'hABCD;
      b     = 16'h1234;
      cin   = 1'b1;

      // Reset held for two edges with live operands, then released.
      step("reset_edge1",   1'b0, 16'hABCD, 16'h1234, 1'b1, 17'h00000);
      step("reset_edge2",   1'b0, 16'hABCD, 16'h1234, 1'b1, 17'h00000);
      step("reset_release", 1'b1, 16'hABCD, 16'h1234, 1'b1, 17'h0BE02);

      // Carry boundary cases.
      step("full_ripple",   1'b1, 16'hFFFF, 16'h0001, 1'b0, 17'h10000);
      step("cin_ripple",    1'b1, 16'hFFFF, 16'h0000, 1'b1, 17'h10000);
      step("no_carry",      1'b1, 16'h1234, 16'h4321, 1'b0, 17'h05555);
      step("msb_carry",     1'b1, 16'h8000, 16'h8000, 1'b1, 17'h10001);

      // Back-to-back stream, cin toggling every cycle.
      step("b2b_0", 1'b1, 16'h0001, 16'h0002, 1'b0, 17'h00003);
      step("b2b_1", 1'b1, 16'h7FFF, 16'h0001, 1'b1, 17'h08001);
      step("b2b_2", 1'b1, 16'hAAAA, 16'h5555, 1'b0, 17'h0FFFF);
      step("b2b_3", 1'b1, 16'hAAAA, 16'h5555, 1'b1, 17'h10000);
      step("b2b_4", 1'b1, 16'hF0F0, 16'h1F0F, 1'b0, 17'h10FFF);
      step("b2b_5", 1'b1, 16'h1357, 16'h2468, 1'b1, 17'h037C0);
      step("b2b_6", 1'b1, 16'hC000, 16'h4000, 1'b0, 17'h10000);
      step("b2b_7", 1'b1, 16'h8421, 16'h1248, 1'b1, 17'h0966A);

      // Reset in the middle of a stream, then resume with one-cycle latency.
      step("mid_pre",    1'b1, 16'h0100, 16'h0200, 1'b0, 17'h00300);
      step("mid_reset",  1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 17'h00000);
      step("mid_resume", 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
      step("mid_next",   1'b1, 16'h0005, 16'h000A, 1'b0, 17'h0000F);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
